// File: rtl/ram_access_ctrl.sv
// Sequencer for the 8x8 RAM macro: precharge, then word-line access with write drive
// or sense, then a one-cycle done. All outputs are registered from the next-state decode.
module ram_access_ctrl #(
  parameter int PRE_CYC = 1,
  parameter int WL_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] sa_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic [2:0] dec_a,
  output logic       dec_en,
  output logic       pre_en,
  output logic       wd_en,
  output logic [7:0] wbl,
  output logic       sa_en
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] PRE_LD = 4'(PRE_CYC - 1);
  localparam logic [3:0] WL_LD  = 4'(WL_CYC - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_we;
  logic [7:0] r_wdata;
  logic       w_accept;

  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_pre_nxt;
  logic       w_dec_nxt;
  logic       w_wd_nxt;
  logic       w_sa_nxt;
  logic [7:0] w_wbl_nxt;
  logic [2:0] w_deca_nxt;
  logic [7:0] w_rdata_nxt;

  assign w_accept = (r_state == S_IDLE) && req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_wdata <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= we;
        r_wdata <= wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_state_nxt = S_PRE;
          w_cnt_nxt   = PRE_LD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_PRE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_ACC;
          w_cnt_nxt   = WL_LD;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_ACC: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they line up with it after the edge
  always_comb begin
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_pre_nxt   = (w_state_nxt == S_PRE);
    w_dec_nxt   = (w_state_nxt == S_ACC);
    w_wd_nxt    = w_dec_nxt && r_we;
    w_sa_nxt    = w_dec_nxt && !r_we && (w_cnt_nxt == 4'd0);
    w_wbl_nxt   = 8'd0;
    w_deca_nxt  = dec_a;
    w_rdata_nxt = rdata;
    if (w_wd_nxt) begin
      w_wbl_nxt = r_wdata;
    end else begin
      w_wbl_nxt = 8'd0;
    end
    if (w_accept) begin
      w_deca_nxt = addr;
    end else begin
      w_deca_nxt = dec_a;
    end
    if ((r_state == S_ACC) && (r_cnt == 4'd0) && !r_we) begin
      w_rdata_nxt = sa_out;
    end else begin
      w_rdata_nxt = rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      pre_en <= 1'b0;
      dec_en <= 1'b0;
      wd_en  <= 1'b0;
      sa_en  <= 1'b0;
      wbl    <= 8'd0;
      dec_a  <= 3'd0;
      rdata  <= 8'd0;
    end else begin
      busy   <= w_busy_nxt;
      done   <= w_done_nxt;
      pre_en <= w_pre_nxt;
      dec_en <= w_dec_nxt;
      wd_en  <= w_wd_nxt;
      sa_en  <= w_sa_nxt;
      wbl    <= w_wbl_nxt;
      dec_a  <= w_deca_nxt;
      rdata  <= w_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: two instances (defaults and PRE_CYC=3/WL_CYC=1) share stimulus;
// a cycle-count model predicts every output of both on every cycle.
module tb_ram_access_ctrl;

  localparam int P0 = 1, W0 = 2, P1 = 3, W1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req = 1'b0;
  logic we = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] sa_out = 8'd0;

  logic [1:0] busy_w, done_w, dec_en_w, pre_en_w, wd_en_w, sa_en_w;
  logic [2:0] dec_a_w [2];
  logic [7:0] rdata_w [2];
  logic [7:0] wbl_w [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_access_ctrl #(.PRE_CYC(P0), .WL_CYC(W0)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .sa_out(sa_out),
    .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]), .dec_a(dec_a_w[0]),
    .dec_en(dec_en_w[0]), .pre_en(pre_en_w[0]), .wd_en(wd_en_w[0]), .wbl(wbl_w[0]),
    .sa_en(sa_en_w[0])
  );

  ram_access_ctrl #(.PRE_CYC(P1), .WL_CYC(W1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .sa_out(sa_out),
    .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]), .dec_a(dec_a_w[1]),
    .dec_en(dec_en_w[1]), .pre_en(pre_en_w[1]), .wd_en(wd_en_w[1]), .wbl(wbl_w[1]),
    .sa_en(sa_en_w[1])
  );

  function automatic int pcyc(input int i);
    return (i == 0) ? P0 : P1;
  endfunction

  function automatic int wcyc(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: t = cycles since acceptance (0 = idle); transaction spans t = 1 .. P+W+1
  int         t [2];
  logic       m_we [2];
  logic [2:0] m_addr [2];
  logic [7:0] m_wd [2];
  logic [7:0] m_rd [2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        t[i] <= 0; m_we[i] <= 1'b0; m_addr[i] <= 3'd0; m_wd[i] <= 8'd0; m_rd[i] <= 8'd0;
      end else if (t[i] == 0) begin
        if (req) begin
          t[i] <= 1; m_we[i] <= we; m_addr[i] <= addr; m_wd[i] <= wdata;
        end
      end else if (t[i] == pcyc(i) + wcyc(i) + 1) begin
        t[i] <= 0;
      end else begin
        if (t[i] == pcyc(i) + wcyc(i) && !m_we[i]) m_rd[i] <= sa_out;
        t[i] <= t[i] + 1;
      end
    end
  end

  // Compare both instances against the model on every cycle
  always @(negedge clk) begin
    int p, w, tt;
    logic e_pre, e_dec, e_wd, e_sa, e_done, e_busy, inv_ok;
    logic [24:0] e_v, a_v;
    for (int i = 0; i < 2; i++) begin
      p = pcyc(i); w = wcyc(i); tt = t[i];
      e_pre  = (tt >= 1) && (tt <= p);
      e_dec  = (tt > p) && (tt <= p + w);
      e_wd   = e_dec && m_we[i];
      e_sa   = e_dec && !m_we[i] && (tt == p + w);
      e_done = (tt == p + w + 1);
      e_busy = (tt != 0);
      e_v = {e_busy, e_done, e_pre, e_dec, e_wd, e_sa, m_addr[i],
             (e_wd ? m_wd[i] : 8'd0), m_rd[i]};
      a_v = {busy_w[i], done_w[i], pre_en_w[i], dec_en_w[i], wd_en_w[i], sa_en_w[i],
             dec_a_w[i], wbl_w[i], rdata_w[i]};
      chk($sformatf("outputs[%0d] {busy,done,pre,dec,wd,sa,dec_a,wbl,rdata}", i),
          32'(a_v), 32'(e_v));
      inv_ok = !(pre_en_w[i] && dec_en_w[i]) && !(wd_en_w[i] && sa_en_w[i]) &&
               ((32'(pre_en_w[i]) + 32'(dec_en_w[i]) + 32'(done_w[i])) <= 32'd1);
      chk($sformatf("invariants[%0d]", i), 32'(inv_ok), 32'd1);
    end
  end

  logic [9:0] rp [2], rdc [2], rs [2], rdn [2], rw [2];
  logic [2:0] ra [2];
  logic [7:0] rwbl [2], rbad [2];

  task automatic wait_idle();
    int n = 0;
    while (busy_w != 2'b00 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_idle", 32'(busy_w), 32'd0);
  endtask

  // Issue one request and record per-cycle enables for cycles 1..9 after acceptance
  task automatic run_txn(input logic w_i, input logic [2:0] a_i, input logic [7:0] d_i,
                         input logic [7:0] s_i);
    wait_idle();
    we = w_i; addr = a_i; wdata = d_i; sa_out = s_i; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rp[i] = '0; rdc[i] = '0; rs[i] = '0; rdn[i] = '0; rw[i] = '0;
      ra[i] = 3'd0; rwbl[i] = 8'd0; rbad[i] = 8'd0;
    end
    for (int k = 1; k <= 9; k++) begin
      for (int i = 0; i < 2; i++) begin
        rp[i][k] = pre_en_w[i]; rdc[i][k] = dec_en_w[i]; rs[i][k] = sa_en_w[i];
        rdn[i][k] = done_w[i]; rw[i][k] = wd_en_w[i];
        if (dec_en_w[i]) ra[i] = dec_a_w[i];
        if (wd_en_w[i]) rwbl[i] = rwbl[i] | wbl_w[i];
        else rbad[i] = rbad[i] | wbl_w[i];
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nacc [2];
    int acc_e [2][4];
    logic [1:0] prev;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      req = 1'b1; we = 1'($urandom); addr = 3'($urandom);
      wdata = 8'($urandom); sa_out = 8'($urandom);
    end
    chk("reset_busy", 32'(busy_w), 32'd0);
    chk("reset_enables", 32'({pre_en_w, dec_en_w, wd_en_w, sa_en_w, done_w}), 32'd0);
    chk("reset_data", 32'({dec_a_w[0], wbl_w[0], rdata_w[0]}), 32'd0);

    // Release with a read pending: first dec_en two cycles after acceptance
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b1; we = 1'b0; addr = 3'd0;
    @(posedge clk); #1;
    req = 1'b0;
    chk("post_reset_dec_cyc1", 32'(dec_en_w[0]), 32'd0);
    @(posedge clk); #1;
    chk("post_reset_dec_cyc2", 32'(dec_en_w[0]), 32'd1);

    // Read addr 5
    run_txn(1'b0, 3'd5, 8'h00, 8'hA5);
    chk("rd_pre0", 32'(rp[0]), 32'h002);  chk("rd_dec0", 32'(rdc[0]), 32'h00C);
    chk("rd_sa0", 32'(rs[0]), 32'h008);   chk("rd_done0", 32'(rdn[0]), 32'h010);
    chk("rd_deca0", 32'(ra[0]), 32'd5);   chk("rd_rdata0", 32'(rdata_w[0]), 32'hA5);
    chk("rd_pre1", 32'(rp[1]), 32'h00E);  chk("rd_dec1", 32'(rdc[1]), 32'h010);
    chk("rd_sa1", 32'(rs[1]), 32'h010);   chk("rd_done1", 32'(rdn[1]), 32'h020);
    chk("rd_rdata1", 32'(rdata_w[1]), 32'hA5);

    // Write addr 3
    run_txn(1'b1, 3'd3, 8'h3C, 8'h77);
    chk("wr_wd0", 32'(rw[0]), 32'h00C);   chk("wr_sa0", 32'(rs[0]), 32'h000);
    chk("wr_wbl0", 32'(rwbl[0]), 32'h3C); chk("wr_wbl_idle0", 32'(rbad[0]), 32'h00);
    chk("wr_done0", 32'(rdn[0]), 32'h010); chk("wr_deca0", 32'(ra[0]), 32'd3);
    chk("wr_rdata_hold0", 32'(rdata_w[0]), 32'hA5);
    chk("wr_wd1", 32'(rw[1]), 32'h010);   chk("wr_done1", 32'(rdn[1]), 32'h020);

    // req held high with addr changing each edge
    wait_idle();
    prev = 2'b00; nacc[0] = 0; nacc[1] = 0;
    for (int j = 1; j <= 10; j++) begin
      addr = 3'(j); we = 1'b0; sa_out = 8'($urandom); req = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (busy_w[i] && !prev[i] && nacc[i] < 4) begin
          acc_e[i][nacc[i]] = j; nacc[i]++;
        end
        prev[i] = busy_w[i];
      end
    end
    req = 1'b0;
    chk("b2b_count0", 32'(nacc[0]), 32'd2);
    chk("b2b_count1", 32'(nacc[1]), 32'd2);
    chk("b2b_first0", 32'(acc_e[0][0]), 32'd1);
    chk("b2b_gap0", 32'(acc_e[0][1] - acc_e[0][0]), 32'd5);
    chk("b2b_gap1", 32'(acc_e[1][1] - acc_e[1][0]), 32'd6);
    wait_idle();
    chk("b2b_deca0", 32'(dec_a_w[0]), 32'd6);
    chk("b2b_deca1", 32'(dec_a_w[1]), 32'd7);

    // Reset in the first ACC cycle of a write, then an immediate read
    wait_idle();
    we = 1'b1; addr = 3'd4; wdata = 8'h5A; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("abort_dec_before", 32'(dec_en_w[0]), 32'd1);
    chk("abort_wd_before", 32'(wd_en_w[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_dec_async", 32'(dec_en_w[0]), 32'd0);
    chk("abort_wd_async", 32'(wd_en_w[0]), 32'd0);
    chk("abort_pre_async1", 32'(pre_en_w[1]), 32'd0);
    #2 rst = 1'b0;
    run_txn(1'b0, 3'd2, 8'h00, 8'hC3);
    chk("after_abort_pre0", 32'(rp[0]), 32'h002);
    chk("after_abort_done0", 32'(rdn[0]), 32'h010);
    chk("after_abort_rdata0", 32'(rdata_w[0]), 32'hC3);
    chk("after_abort_done1", 32'(rdn[1]), 32'h020);

    // Random traffic with occasional asynchronous resets
    for (int n = 0; n < 400; n++) begin
      req = ($urandom_range(0, 2) == 0);
      we = 1'($urandom); addr = 3'($urandom);
      wdata = 8'($urandom); sa_out = 8'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; req = 1'b0;
    wait_idle();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
